seg_scan_scheduler: RTL and testbench

- Time-multiplexes the single shared 7-segment decoder and segment bus of the 4-bit adder display among DIGITS digit requesters.
- An internal clock-enable divider sets the scan rate. No derived clocks: everything runs on clk_in.
- Adds a blanking gap between digits to suppress ghosting, and skips digits that are not enabled, in round-robin order.
- Sits between the adder/BCD logic (digit values) and the hex-to-7-seg decoder plus anode pins.

---
 rtl/seg_scan_scheduler_pkg.sv | 15 +
 rtl/seg_scan_scheduler_tick_gen.sv | 30 +++
 rtl/seg_scan_scheduler.sv | 132 +++++++++++++
 tb/tb_seg_scan_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_scheduler_pkg.sv
// Shared constants for the 7-segment scan scheduler.
//   - FSM state encoding (IDLE / BLANK / SHOW)
//   - Default divider terminal count and blanking length for a 50 MHz clk_in
package seg_scan_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // 25000 cycles per scan slot -> 2 kHz digit rate at 50 MHz
  localparam logic [15:0] DEF_TICK_LIMIT   = 16'd24999;
  // 10 us of all-anodes-off before each digit
  localparam int          DEF_BLANK_CYCLES = 500;

endpackage

// File: rtl/seg_scan_scheduler_tick_gen.sv
// Free-running terminal-count divider producing a one-cycle clock enable.
// Ports:
//   clk_in  - system clock
//   rst_n   - synchronous active-low reset (counter restarts from 0)
//   tick_en - high for the whole cycle in which the counter sits at TICK_LIMIT;
//             the counter wraps to 0 on the edge that ends that cycle
module scan_tick_gen #(
  parameter int                  CNT_SIZE   = 16,
  parameter logic [CNT_SIZE-1:0] TICK_LIMIT = CNT_SIZE'(24999)
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick_en
);

  logic [CNT_SIZE-1:0] cnt;

  assign tick_en = (cnt == TICK_LIMIT);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Round-robin scan scheduler sharing one hex-to-7-seg decoder among DIGITS digits.
// Each scan tick grants the next enabled digit: the nibble and decimal point are
// latched, all anodes stay off for BLANK_CYCLES cycles (anti-ghosting), then the
// granted digit's anode is driven low until the next tick.
// Ports:
//   clk_in     - system clock, the only clock
//   rst_n      - synchronous active-low reset
//   digit_en   - per-digit display request
//   digit_val  - packed nibbles, digit i at [4i+3:4i]
//   dp_in      - per-digit decimal point request
//   hex_out    - nibble for the shared decoder (latched at grant)
//   dp_out     - decimal point of the granted digit (latched at grant)
//   an_out     - active-low anodes, at most one low
//   scan_tick  - registered one-cycle pulse per divider terminal count
//   frame_done - one-cycle pulse when a grant wraps to the lowest enabled digit
module seg_scan_scheduler
  import seg_scan_scheduler_pkg::*;
#(
  parameter int                  DIGITS       = 4,
  parameter int                  CNT_SIZE     = 16,
  parameter logic [CNT_SIZE-1:0] TICK_LIMIT   = CNT_SIZE'(DEF_TICK_LIMIT),
  parameter int                  BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [4*DIGITS-1:0]   digit_val,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            hex_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  scan_tick,
  output logic                  frame_done
);

  localparam int                  SEL_W      = $clog2(DIGITS);
  localparam logic [CNT_SIZE-1:0] BLANK_LAST = CNT_SIZE'(BLANK_CYCLES - 1);

  logic                tick;
  logic [1:0]          state;
  logic [SEL_W-1:0]    sel;
  logic [CNT_SIZE-1:0] bcnt;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_wrap;
  logic [DIGITS-1:0]   an_show;

  scan_tick_gen #(
    .CNT_SIZE   (CNT_SIZE),
    .TICK_LIMIT (TICK_LIMIT)
  ) u_tick (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .tick_en (tick)
  );

  // Returns {wrap, index}: lowest enabled index above cur, else the lowest
  // enabled index overall (a wrap, which includes reselecting cur alone).
  function automatic logic [SEL_W:0] next_pick(input logic [DIGITS-1:0] en,
                                               input logic [SEL_W-1:0]  cur);
    logic [SEL_W-1:0] first_any;
    logic [SEL_W-1:0] first_above;
    logic             found_above;
    first_any   = '0;
    first_above = '0;
    found_above = 1'b0;
    // Descending scan so the last hit is the lowest qualifying index
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (en[i]) begin
        first_any = SEL_W'(i);
        if (i > int'(cur)) begin
          first_above = SEL_W'(i);
          found_above = 1'b1;
        end
      end
    end
    return found_above ? {1'b0, first_above} : {1'b1, first_any};
  endfunction

  assign {pick_wrap, pick_idx} = next_pick(digit_en, sel);
  assign an_show = ~(DIGITS'(1) << sel);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= SEL_W'(DIGITS - 1);
      bcnt       <= '0;
      hex_out    <= 4'h0;
      dp_out     <= 1'b0;
      an_out     <= '1;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      scan_tick  <= tick;
      frame_done <= 1'b0;
      case (state)
        // Ticks cannot land here while BLANK_CYCLES < TICK_LIMIT; ignore any that do
        ST_BLANK: begin
          if (bcnt == BLANK_LAST) begin
            state  <= ST_SHOW;
            an_out <= an_show;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_IDLE, ST_SHOW: begin
          if (tick) begin
            an_out <= '1;
            if (|digit_en) begin
              sel        <= pick_idx;
              hex_out    <= digit_val[4*pick_idx +: 4];
              dp_out     <= dp_in[pick_idx];
              frame_done <= pick_wrap;
              bcnt       <= '0;
              state      <= ST_BLANK;
            end else begin
              state <= ST_IDLE;
            end
          end else if (state == ST_SHOW && !digit_en[sel]) begin
            // Requester withdrew: go dark and wait for the next tick
            state  <= ST_IDLE;
            an_out <= '1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          an_out <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
module tb_seg_scan_scheduler;

  localparam int DIGITS = 4;
  localparam int TL     = 9;
  localparam int BC     = 2;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [3:0]  digit_en;
  logic [15:0] digit_val;
  logic [3:0]  dp_in;
  logic [3:0]  hex_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        scan_tick;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic       st;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_scheduler #(
    .DIGITS       (DIGITS),
    .CNT_SIZE     (16),
    .TICK_LIMIT   (16'd9),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .digit_en   (digit_en),
    .digit_val  (digit_val),
    .dp_in      (dp_in),
    .hex_out    (hex_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .scan_tick  (scan_tick),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the display schedule in terms of digits and time slots.
  // k counts clock edges since reset; every (TL+1)th edge is a tick.
  int         m_k = 0;
  int         m_mode = 0;       // 0 dark-waiting, 1 blanking, 2 showing
  int         m_sel = DIGITS - 1;
  int         m_left = 0;
  logic [3:0] m_hex = 0;
  logic       m_dp = 0;
  logic       m_st = 0;
  logic       m_fd = 0;

  always @(posedge clk_in) begin
    exp_t e;
    bit   tick;
    int   nxt;
    if (!rst_n) begin
      m_k = 0; m_mode = 0; m_sel = DIGITS - 1;
      m_hex = 0; m_dp = 0; m_st = 0; m_fd = 0;
    end else begin
      tick = ((m_k % (TL + 1)) == TL);
      m_k++;
      m_st = tick;
      m_fd = 0;
      if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end else if (tick) begin
        if (digit_en != 0) begin
          nxt = -1;
          for (int j = m_sel + 1; j < DIGITS; j++)
            if (digit_en[j] && nxt < 0) nxt = j;
          if (nxt < 0) begin
            m_fd = 1;
            for (int j = 0; j < DIGITS; j++)
              if (digit_en[j] && nxt < 0) nxt = j;
          end
          m_sel  = nxt;
          m_hex  = digit_val[4*m_sel +: 4];
          m_dp   = dp_in[m_sel];
          m_mode = 1;
          m_left = BC;
        end else begin
          m_mode = 0;
        end
      end else if (m_mode == 2 && !digit_en[m_sel]) begin
        m_mode = 0;
      end
    end
    e.an  = (m_mode == 2) ? ~(4'b0001 << m_sel) : 4'b1111;
    e.hex = m_hex;
    e.dp  = m_dp;
    e.st  = m_st;
    e.fd  = m_fd;
    exp_q.push_back(e);
  end

  // Monitor: one expected record per clock edge, compared mid-cycle
  always @(negedge clk_in) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an_out, hex: hex_out, dp: dp_out, st: scan_tick, fd: frame_done};
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 30)
          $display("FAIL cycle_outputs: got an=%b hex=%h dp=%b tick=%b fd=%b expected an=%b hex=%h dp=%b tick=%b fd=%b at %0t",
                   a.an, a.hex, a.dp, a.st, a.fd, e.an, e.hex, e.dp, e.st, e.fd, $time);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    digit_en  = 4'b1111;
    digit_val = 16'h4321;
    dp_in     = 4'b0000;
    repeat (3) @(negedge clk_in);
    check("reset_an", {12'h0, an_out}, 16'h000f);
    check("reset_hex", {12'h0, hex_out}, 16'h0000);
    check("reset_pulses", {13'h0, dp_out, scan_tick, frame_done}, 16'h0000);
    rst_n = 1'b1;                        // next posedge is edge 0
    repeat (9) @(negedge clk_in);        // after edge 8
    check("pre_tick", {11'h0, scan_tick, an_out}, 16'h000f);
    @(negedge clk_in);                   // after edge 9
    check("first_tick", {11'h0, scan_tick, an_out}, 16'h001f);
    check("first_latch", {12'h0, hex_out}, 16'h0001);
    repeat (2) @(negedge clk_in);        // after edge 11
    check("digit0_show", {8'h0, an_out, hex_out}, 16'h00e1);
    repeat (10) @(negedge clk_in);       // after edge 21
    check("digit1_show", {8'h0, an_out, hex_out}, 16'h00d2);
    digit_val = 16'h9876;
    repeat (4) @(negedge clk_in);        // after edge 25
    check("val_hold_in_show", {8'h0, an_out, hex_out}, 16'h00d2);
    repeat (6) @(negedge clk_in);        // after edge 31
    check("digit2_new_val", {8'h0, an_out, hex_out}, 16'h00b8);

    digit_en = 4'b1010;
    repeat (60) @(negedge clk_in);
    digit_en = 4'b0000;
    repeat (40) @(negedge clk_in);
    check("idle_dark", {12'h0, an_out}, 16'h000f);
    digit_en = 4'b1111;
    repeat (30) @(negedge clk_in);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) digit_val = 16'($urandom);
      dp_in = 4'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      @(negedge clk_in);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
